// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the fetch/data memory port arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_t;
  localparam int MEM_LAT_DEF = 1;
  localparam int STARVE_MAX_DEF = 4;
  localparam resp_t RESP_NONE = '{valid: 1'b0, owner: OWN_IF};
endpackage

// File: rtl/resp_tracker.sv
// resp_tracker: latency-matched shift register of {valid, owner} with flush of fetch-owned entries
module resp_tracker import mem_arb_pkg::*; #(
  parameter int DEPTH = MEM_LAT_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  resp_t push_i,
  input  logic  flush_i,
  output resp_t tail_o
);
  resp_t stage_q [DEPTH];
  resp_t stage_d [DEPTH];
  always_comb begin
    stage_d[0] = push_i;
    for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    // the flush also catches the entry being pushed at this edge
    for (int k = 0; k < DEPTH; k++)
      if (flush_i && stage_d[k].owner == OWN_IF) stage_d[k].valid = 1'b0;
  end
  always_ff @(posedge clk)
    if (!reset) for (int k = 0; k < DEPTH; k++) stage_q[k] <= RESP_NONE;
    else stage_q <= stage_d;
  assign tail_o = stage_q[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with bounded fetch starvation
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic if_elig, starved;
  resp_t push, tail;
  always_comb begin
    if_elig = if_req & ~if_flush;
    starved = (starve_q == SW'(STARVE_MAX));
    // data has priority until fetch has been denied STARVE_MAX times in a row
    if_gnt = reset & if_elig & (~d_req | starved);
    d_gnt = reset & d_req & ~if_gnt;
    mem_en = if_gnt | d_gnt;
    mem_we = d_gnt & d_we;
    mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = mem_en ? d_wdata : '0;
    stall_if = reset & if_req & ~if_gnt;
    stall_mem = reset & d_req & ~d_gnt;
    push = '{valid: mem_en & ~mem_we, owner: d_gnt ? OWN_D : OWN_IF};
    starve_d = (if_elig & ~if_gnt) ? (starved ? starve_q : starve_q + 1'b1) : '0;
    if_rvalid = reset & tail.valid & (tail.owner == OWN_IF);
    d_rvalid = reset & tail.valid & (tail.owner == OWN_D);
    if_rdata = if_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk)
    starve_q <= !reset ? '0 : starve_d;
  resp_tracker #(.DEPTH(MEM_LAT)) u_trk (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .flush_i (if_flush),
    .tail_o  (tail)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (MEM_LAT 1..3) on shared directed stimulus vs a per-cycle schedule model
module tb_mem_port_arbiter;
  localparam int NC = 512;
  localparam int SMAX = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w, mem_en_w, mem_we_w, stall_if_w, stall_mem_w;
  logic [31:0] if_rdata_w [3];
  logic [31:0] d_rdata_w [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] mem_wdata_w [3];
  logic [31:0] mem_rdata_w [3];
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[lat%0d] cyc=%0d got=%h want=%h", nm, i + 1, cyc, act, exp);
    end
  endtask

  task automatic chkb(input int i, input string nm, input logic act, input logic exp);
    chk(i, nm, {31'd0, act}, {31'd0, exp});
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    logic pv [g+1];
    logic [31:0] pa [g+1];
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt_w[g]), .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[g]), .d_rvalid(d_rvalid_w[g]), .d_rdata(d_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g]),
      .stall_if(stall_if_w[g]), .stall_mem(stall_mem_w[g])
    );
    // memory with g+1 cycles of read latency; garbage when no read is due
    always @(posedge clk) begin
      pv[0] <= mem_en_w[g] & ~mem_we_w[g];
      pa[0] <= mem_addr_w[g];
      for (int k = 1; k <= g; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
    assign mem_rdata_w[g] = pv[g] ? f(pa[g]) : 32'hBAD0BAD0;
  end

  // model: expected responses are booked into absolute-cycle slots
  logic ev_if [3][NC];
  logic ev_d [3][NC];
  logic [31:0] ed_if [3][NC];
  logic [31:0] ed_d [3][NC];
  int sc;
  logic e_if, e_d, e_en;
  logic [31:0] e_addr;

  initial begin
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NC; c++) begin
        ev_if[i][c] = 1'b0; ev_d[i][c] = 1'b0; ed_if[i][c] = '0; ed_d[i][c] = '0;
      end
    sc = 0;
    forever begin
      @(negedge clk);
      if (!reset)
        for (int i = 0; i < 3; i++)
          for (int c = cyc; c < NC; c++) begin ev_if[i][c] = 1'b0; ev_d[i][c] = 1'b0; end
      e_if = reset && if_req && !if_flush && (!d_req || sc == SMAX);
      e_d = reset && d_req && !e_if;
      e_en = e_if || e_d;
      e_addr = e_d ? d_addr : e_if ? if_addr : 32'd0;
      for (int i = 0; i < 3; i++) begin
        chkb(i, "if_gnt", if_gnt_w[i], e_if);
        chkb(i, "d_gnt", d_gnt_w[i], e_d);
        chkb(i, "stall_if", stall_if_w[i], reset && if_req && !e_if);
        chkb(i, "stall_mem", stall_mem_w[i], reset && d_req && !e_d);
        chkb(i, "mem_en", mem_en_w[i], e_en);
        chkb(i, "mem_we", mem_we_w[i], e_d && d_we);
        chk(i, "mem_addr", mem_addr_w[i], e_addr);
        chk(i, "mem_wdata", mem_wdata_w[i], e_en ? d_wdata : 32'd0);
        chkb(i, "if_rvalid", if_rvalid_w[i], ev_if[i][cyc]);
        chk(i, "if_rdata", if_rdata_w[i], ev_if[i][cyc] ? ed_if[i][cyc] : 32'd0);
        chkb(i, "d_rvalid", d_rvalid_w[i], ev_d[i][cyc]);
        chk(i, "d_rdata", d_rdata_w[i], ev_d[i][cyc] ? ed_d[i][cyc] : 32'd0);
        if (cyc + 4 < NC) begin
          if (e_if) begin ev_if[i][cyc+i+1] = 1'b1; ed_if[i][cyc+i+1] = f(if_addr); end
          if (e_d && !d_we) begin ev_d[i][cyc+i+1] = 1'b1; ed_d[i][cyc+i+1] = f(d_addr); end
        end
        if (reset && if_flush)
          for (int c = cyc + 1; c < NC; c++) ev_if[i][c] = 1'b0;
      end
      sc = (reset && if_req && !if_flush && !e_if) ? ((sc < SMAX) ? sc + 1 : SMAX) : 0;
      cyc++;
    end
  end

  task automatic drive(input logic rs, ifr, fl, dr, we, input logic [31:0] ia, da, wd);
    @(posedge clk);
    #1;
    reset = rs; if_req = ifr; if_flush = fl; d_req = dr; d_we = we;
    if_addr = ia; d_addr = da; d_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [9:0] gp;

  initial begin
    drive(0, 1, 0, 1, 0, 'h10, 'h20, 0);
    chkb(0, "rst any mem_en", |mem_en_w, 1'b0);
    chkb(0, "rst any gnt", |{if_gnt_w, d_gnt_w}, 1'b0);
    chkb(0, "rst any stall", |{stall_if_w, stall_mem_w}, 1'b0);
    drive(0, 1, 0, 1, 0, 'h10, 'h20, 0);
    idle(1);
    drive(1, 1, 0, 0, 0, 'h10, 0, 0);
    chkb(0, "iso if_gnt", if_gnt_w[0], 1'b1);
    chk(0, "iso mem_addr", mem_addr_w[0], 32'h10);
    idle(1);
    chkb(0, "iso if_rvalid", if_rvalid_w[0], 1'b1);
    chk(0, "iso if_rdata", if_rdata_w[0], 32'hDEADBEEF);
    chkb(0, "iso d_rvalid", d_rvalid_w[0], 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 1, 0, 'h30, 'h40 + k, 0);
      chkb(0, "cont d_gnt", &d_gnt_w, 1'b1);
      chkb(0, "cont stall_if", &stall_if_w, 1'b1);
    end
    drive(1, 1, 0, 0, 0, 'h30, 0, 0);
    chkb(0, "cont if_gnt 4th", &if_gnt_w, 1'b1);
    idle(1);
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 1, 0, 'h60, 'h50, 0);
      gp[k] = if_gnt_w[0];
      if (k == 4) chkb(0, "starve stall_mem", stall_mem_w[0], 1'b1);
    end
    chk(0, "starve pattern", {22'd0, gp}, 32'h210);
    idle(1);
    drive(1, 0, 0, 1, 1, 0, 'h20, 'h55);
    chkb(0, "store mem_we", &mem_we_w, 1'b1);
    chk(0, "store mem_wdata", mem_wdata_w[0], 32'h55);
    chk(0, "store mem_addr", mem_addr_w[0], 32'h20);
    idle(4);
    drive(1, 1, 0, 0, 0, 'h70, 0, 0);
    drive(1, 1, 1, 1, 0, 'h80, 'h44, 0);
    chkb(2, "flush d_gnt", d_gnt_w[2], 1'b1);
    chkb(2, "flush if_gnt", if_gnt_w[2], 1'b0);
    idle(2);
    chkb(2, "flush no if_rvalid", if_rvalid_w[2], 1'b0);
    idle(1);
    chkb(2, "flush d_rvalid", d_rvalid_w[2], 1'b1);
    chk(2, "flush d_rdata", d_rdata_w[2], 32'h0044FFBB);
    idle(2);
    drive(1, 1, 0, 0, 0, 'h90, 0, 0);
    drive(0, 1, 0, 1, 0, 'h90, 'h91, 0);
    drive(0, 1, 0, 1, 0, 'h90, 'h91, 0);
    chkb(1, "rstmid if_rvalid", |if_rvalid_w, 1'b0);
    chkb(1, "rstmid d_rvalid", |d_rvalid_w, 1'b0);
    chkb(1, "rstmid mem_en", |mem_en_w, 1'b0);
    idle(3);
    for (int k = 0; k < 24; k++)
      drive(1, k % 3 != 0, k % 5 == 2, k % 2 == 0, k % 7 == 3, 'hA0 + k, 'hC0 + k, k * 3);
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-port unified memory between the IF-stage instruction fetch port and the MEM-stage load/store port of the five-stage pipeline. Grants at most one access per cycle, routes read data back to the owning port after a fixed memory latency, and drives per-port stall outputs that freeze the PC/IF_ID path or the MEM stage while a request waits. A starvation counter bounds how long fetch can be locked out by back-to-back data traffic.

## Interface
Parameters:
- ADDR_W, 32, address width (word addresses; PC increments by 1)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..4
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win; legal range ≥1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with stable `if_addr` until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect: kill in-flight fetch responses, block fetch grant this cycle
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data (0 when `if_rvalid`=0)
- d_req  in  1  data request; held stable until `d_gnt`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data (0 when `d_rvalid`=0)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe
- stall_if  out  1  `if_req & ~if_gnt`
- stall_mem  out  1  `d_req & ~d_gnt`

## Operation
- Arbitration (combinational, same cycle as request):
  - `reset`=0: no grants, `mem_en`=0.
  - Fetch is eligible only if `if_req & ~if_flush`.
  - Only one eligible port: that port is granted.
  - Both eligible: data wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- Memory drive: `mem_en` = any grant. `mem_addr` comes from the winning port. `mem_we` = `d_gnt & d_we`. `mem_wdata` = `d_wdata`. All memory outputs are 0 when no grant is made.
- Starvation counter `starve_cnt`:
  - Increments (saturating at STARVE_MAX) when `if_req & ~if_flush & ~if_gnt`.
  - Clears to 0 on `if_gnt`, on `~if_req`, or on `if_flush`.
- Response tracker: MEM_LAT-deep shift register; each stage holds {valid, owner}.
  - A granted read pushes valid=1 with owner IF or D.
  - A granted write, or no grant, pushes valid=0.
  - At the tail: valid & owner=IF drives `if_rvalid`=1 and `if_rdata`=`mem_rdata`; owner=D drives the `d_` outputs the same way.
- Flush: `if_flush`=1 clears valid on every IF-owned entry in the tracker at that edge, including the entry pushed that cycle. Those responses never assert `if_rvalid`. D-owned entries are untouched.
- Simultaneous `if_flush` and `d_req`: the data request is granted normally.

## Timing
- Grant latency: 0 cycles (combinational from `*_req`).
- Read response: `*_rvalid` asserts exactly MEM_LAT cycles after the granting edge, for one cycle.
- Throughput: one access per cycle, fully pipelined, no bubbles between back-to-back grants.
- Reset values: tracker all invalid, `starve_cnt`=0; `if_rvalid`=`d_rvalid`=0, rdata outputs 0, grants 0, `mem_*` 0, stalls 0.
- Reset mid-operation: in-flight responses are dropped and never reported.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX+1 cycles.
- Stores produce no response. A load and a fetch may not complete in the same cycle, because grants are exclusive.

## Structure
- Package `mem_arb_pkg`:
  - owner enum `OWN_IF`, `OWN_D`
  - response-entry struct {valid, owner}
  - default constants MEM_LAT_DEF, STARVE_MAX_DEF
- Sub-module `resp_tracker`: parameterised shift register with push and flush-by-owner. The arbiter, starvation counter and muxing stay in `mem_port_arbiter`.

## Test plan
- **Isolated fetch, MEM_LAT=1:** `if_req`=1, `if_addr`=0x10 for one cycle, mem returns 0xDEADBEEF → `if_gnt`=1 in the same cycle, `mem_addr`=0x10; next cycle `if_rvalid`=1, `if_rdata`=0xDEADBEEF; `d_rvalid` stays 0.
- **Contention:** both ports request for 3 cycles, STARVE_MAX=4 → `d_gnt` for 3 cycles; `stall_if`=1 for 3 cycles; `starve_cnt` reaches 3; fetch is granted on the 4th cycle once `d_req` drops.
- **Starvation:** `d_req` held continuously, `if_req` held, STARVE_MAX=4 → 4 data grants, then 1 fetch grant (`stall_mem`=1 that cycle), then data resumes; the pattern repeats every 5 cycles.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x20, `d_wdata`=0x55 → `mem_we`=1, `mem_wdata`=0x55; no `d_rvalid` ever follows.
- **Flush, MEM_LAT=3:** fetch granted at cycle 0, `if_flush`=1 at cycle 1 → no `if_rvalid` at cycle 3. A load granted at cycle 1 still returns `d_rvalid` at cycle 4.
- **Reset mid-flight, MEM_LAT=2:** read granted at cycle 0, `reset`=0 at cycle 1 → no `*_rvalid` at cycle 2; all outputs 0 while reset is held.
